// File: rtl/cv32e40px_pkg.sv
// Shared package for the cv32e40px block slice.
// Holds the state type for the index collector. Widths derive from LEN inside
// each module, so no width constants are kept here.
package cv32e40px_pkg;

  // ACCUM: gathering index beats. HOLD: finished mask offered downstream.
  typedef enum logic [0:0] {
    IC_ACCUM = 1'b0,
    IC_HOLD  = 1'b1
  } idx_collect_state_e;

endpackage

// File: rtl/cv32e40px_onehot_dec.sv
// Combinational index-to-one-hot decoder.
// Ports:
//   in_i     [IW-1:0]  bit index
//   onehot_o [LEN-1:0] one-hot decode of in_i (all zero when out of range)
//   oor_o              in_i >= LEN (only reachable when LEN is not a power of two)
module cv32e40px_onehot_dec #(
  parameter int unsigned LEN = 32,
  parameter int unsigned IW  = $clog2(LEN)
) (
  input  logic [IW-1:0]  in_i,
  output logic [LEN-1:0] onehot_o,
  output logic           oor_o
);

  for (genvar i = 0; i < LEN; i++) begin : g_bit
    assign onehot_o[i] = (in_i == IW'(i));
  end

  // No bit matched means the index lies past the top of the mask.
  assign oor_o = ~|onehot_o;

endmodule

// File: rtl/cv32e40px_idx_collect.sv
// Streaming index-to-mask collector.
// Index beats arriving on a valid/ready handshake are decoded to one-hot and
// ORed into a LEN-bit mask. The beat flagged last closes the mask, which is then
// offered with its population count and duplicate / out-of-range flags on an
// output valid/ready handshake.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clear_i         synchronous abort of the partial or pending mask
//   idx_valid_i / idx_ready_o / idx_i / idx_last_i   index input stream
//   mask_valid_o / mask_ready_i                      mask output handshake
//   mask_o, count_o, empty_o, dup_o, oor_o           mask and its attributes
module cv32e40px_idx_collect
  import cv32e40px_pkg::*;
#(
  parameter int unsigned LEN = 32,
  parameter int unsigned IW  = $clog2(LEN),
  parameter int unsigned CW  = $clog2(LEN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_i,
  input  logic           idx_valid_i,
  output logic           idx_ready_o,
  input  logic [IW-1:0]  idx_i,
  input  logic           idx_last_i,
  output logic           mask_valid_o,
  input  logic           mask_ready_i,
  output logic [LEN-1:0] mask_o,
  output logic [CW-1:0]  count_o,
  output logic           empty_o,
  output logic           dup_o,
  output logic           oor_o
);

  idx_collect_state_e state_q;
  logic [LEN-1:0]     mask_q;
  logic [CW-1:0]      count_q;
  logic               dup_q;
  logic               oor_q;

  logic [LEN-1:0]     onehot;
  logic               idx_oor;
  logic               idx_dup;

  cv32e40px_onehot_dec #(
    .LEN (LEN),
    .IW  (IW)
  ) u_dec (
    .in_i     (idx_i),
    .onehot_o (onehot),
    .oor_o    (idx_oor)
  );

  assign idx_dup = |(mask_q & onehot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IC_ACCUM;
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else if (clear_i) begin
      // Any beat or handoff this cycle still completes but its content is lost.
      state_q <= IC_ACCUM;
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IC_ACCUM: begin
          if (idx_valid_i) begin
            if (idx_oor) begin
              oor_q <= 1'b1;
            end else begin
              mask_q <= mask_q | onehot;
              // Duplicates never count, so count_q tops out at LEN.
              if (idx_dup) begin
                dup_q <= 1'b1;
              end else begin
                count_q <= count_q + CW'(1);
              end
            end
            if (idx_last_i) begin
              state_q <= IC_HOLD;
            end
          end
        end
        IC_HOLD: begin
          if (mask_ready_i) begin
            state_q <= IC_ACCUM;
            mask_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
            oor_q   <= 1'b0;
          end
        end
        default: state_q <= IC_ACCUM;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register; no same-cycle turnaround.
  assign idx_ready_o  = (state_q == IC_ACCUM);
  assign mask_valid_o = (state_q == IC_HOLD);
  assign mask_o       = mask_q;
  assign count_o      = count_q;
  assign empty_o      = (count_q == '0);
  assign dup_o        = dup_q;
  assign oor_o        = oor_q;

endmodule
